load_mem_ctrl: RTL and testbench

LOAD_MEM_CTRL -- requirements
Module: load_mem_ctrl

---
 rtl/load_mem_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_load_mem_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_mem_ctrl.sv
// load_mem_ctrl
//    Load path controller between the MEM pipeline stage and a data memory.
//    It accepts a load request in IDLE and checks the alignment and size of
//    the request. For a legal request it issues a single word-aligned read
//    strobe, then waits (bounded by TIMEOUT cycles) for the read data. It
//    then extracts and extends the addressed byte, half or word, and reports
//    completion with a one-cycle o_valid pulse. Misaligned or reserved-size
//    requests, and reads that time out, complete with o_error and an
//    all-ones result.
//
// Ports
//    i_clk, i_reset    clock, asynchronous active-high reset
//    i_req             load request (sampled in IDLE only)
//    i_addr            byte address
//    i_size            00 word, 01 byte, 10 half, 11 reserved
//    i_unsigned        zero-extend byte/half results
//    o_mem_rd_en       memory read strobe (one cycle, REQ state)
//    o_mem_addr        word-aligned memory address (held between loads)
//    i_mem_rdata       memory read word, little-endian lanes
//    i_mem_rvalid      i_mem_rdata valid this cycle
//    o_dato            extended load result, held until next completion
//    o_valid           one-cycle completion pulse
//    o_error           error flag, pulses together with o_valid
//    o_stall           pipeline stall request
module load_mem_ctrl #(
   parameter int NBITS   = 32,
   parameter int TNBITS  = 2,
   parameter int TIMEOUT = 16
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_req,
   input  logic [NBITS-1:0]  i_addr,
   input  logic [TNBITS-1:0] i_size,
   input  logic              i_unsigned,
   output logic              o_mem_rd_en,
   output logic [NBITS-1:0]  o_mem_addr,
   input  logic [NBITS-1:0]  i_mem_rdata,
   input  logic              i_mem_rvalid,
   output logic [NBITS-1:0]  o_dato,
   output logic              o_valid,
   output logic              o_error,
   output logic              o_stall
);

   localparam int NLANES  = NBITS / 8;
   localparam int NHALVES = NBITS / 16;
   localparam int CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0]     CNT_LAST = CW'(TIMEOUT - 1);
   localparam logic [TNBITS-1:0] SZ_WORD  = TNBITS'(0);
   localparam logic [TNBITS-1:0] SZ_BYTE  = TNBITS'(1);
   localparam logic [TNBITS-1:0] SZ_HALF  = TNBITS'(2);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t            state_reg;
   logic [CW-1:0]     cnt_reg;
   logic [1:0]        lane_reg;
   logic [TNBITS-1:0] size_reg;
   logic              unsigned_reg;
   logic              rd_en_reg;
   logic              valid_reg;
   logic              error_reg;
   logic [NBITS-1:0]  mem_addr_reg;
   logic [NBITS-1:0]  dato_reg;

   logic              legal;
   logic [7:0]        sel_byte;
   logic [15:0]       sel_half;
   logic [NBITS-1:0]  load_data;

   // Byte and halfword views of the returned memory word.
   logic [7:0]  byte_lane [NLANES];
   logic [15:0] half_lane [NHALVES];

   genvar gi;
   generate
      for (gi = 0; gi < NLANES; gi++) begin : g_byte_lane
         assign byte_lane[gi] = i_mem_rdata[8*gi +: 8];
      end
      for (gi = 0; gi < NHALVES; gi++) begin : g_half_lane
         assign half_lane[gi] = i_mem_rdata[16*gi +: 16];
      end
   endgenerate

   // Alignment/size legality of the incoming request.
   always_comb begin
      legal = 1'b0;
      case (i_size)
         SZ_WORD: legal = (i_addr[1:0] == 2'b00);
         SZ_BYTE: legal = 1'b1;
         SZ_HALF: legal = ~i_addr[0];
         default: legal = 1'b0;
      endcase
   end

   // Lane select and extension use the request parameters latched in IDLE,
   // so the MEM stage is free to change its inputs while the load is in flight.
   always_comb begin
      sel_byte  = byte_lane[lane_reg];
      sel_half  = half_lane[lane_reg[1]];
      load_data = i_mem_rdata;
      case (size_reg)
         SZ_BYTE: load_data = {{(NBITS-8){sel_byte[7] & ~unsigned_reg}}, sel_byte};
         SZ_HALF: load_data = {{(NBITS-16){sel_half[15] & ~unsigned_reg}}, sel_half};
         default: load_data = i_mem_rdata;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_reg    <= IDLE;
         cnt_reg      <= '0;
         lane_reg     <= 2'b00;
         size_reg     <= '0;
         unsigned_reg <= 1'b0;
         rd_en_reg    <= 1'b0;
         valid_reg    <= 1'b0;
         error_reg    <= 1'b0;
         mem_addr_reg <= '0;
         dato_reg     <= '0;
      end else begin
         // Strobes are single-cycle by default; each transition sets them.
         rd_en_reg <= 1'b0;
         valid_reg <= 1'b0;
         error_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (i_req) begin
                  if (legal) begin
                     lane_reg     <= i_addr[1:0];
                     size_reg     <= i_size;
                     unsigned_reg <= i_unsigned;
                     mem_addr_reg <= {i_addr[NBITS-1:2], 2'b00};
                     rd_en_reg    <= 1'b1;
                     state_reg    <= REQ;
                  end else begin
                     // Illegal access never touches memory.
                     dato_reg  <= '1;
                     valid_reg <= 1'b1;
                     error_reg <= 1'b1;
                     state_reg <= DONE;
                  end
               end
            end
            REQ: begin
               // Any rvalid seen here belongs to nothing we issued; ignore it.
               cnt_reg   <= '0;
               state_reg <= WAIT;
            end
            WAIT: begin
               if (i_mem_rvalid) begin
                  dato_reg  <= load_data;
                  valid_reg <= 1'b1;
                  state_reg <= DONE;
               end else if (cnt_reg == CNT_LAST) begin
                  // TIMEOUT WAIT cycles without data: give up.
                  dato_reg  <= '1;
                  valid_reg <= 1'b1;
                  error_reg <= 1'b1;
                  state_reg <= DONE;
               end else begin
                  cnt_reg <= cnt_reg + CW'(1);
               end
            end
            DONE: begin
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign o_mem_rd_en = rd_en_reg;
   assign o_mem_addr  = mem_addr_reg;
   assign o_dato      = dato_reg;
   assign o_valid     = valid_reg;
   assign o_error     = error_reg;

   // The IDLE term is combinational so the pipeline stalls in the same cycle
   // the request is accepted; it is masked while reset is asserted.
   assign o_stall = (state_reg == REQ) || (state_reg == WAIT) ||
                    ((state_reg == IDLE) && i_req && legal && !i_reset);

endmodule

// File: tb/tb_load_mem_ctrl.sv
// Testbench for load_mem_ctrl: table of directed loads, hand-written
// sequences for held requests and reset mid-load, and randomized loads
// checked against a behavioural model of the load semantics.
module tb_load_mem_ctrl;

   localparam int TIMEOUT = 16;

   logic        clk;
   logic        rst;
   logic        req;
   logic [31:0] addr;
   logic [1:0]  size;
   logic        uns;
   logic        rd_en;
   logic [31:0] mem_addr;
   logic [31:0] rdata;
   logic        rvalid;
   logic [31:0] dato;
   logic        valid;
   logic        error;
   logic        stall;

   int n_checks = 0;
   int n_pass   = 0;

   load_mem_ctrl #(.NBITS(32), .TNBITS(2), .TIMEOUT(TIMEOUT)) dut (
      .i_clk        (clk),
      .i_reset      (rst),
      .i_req        (req),
      .i_addr       (addr),
      .i_size       (size),
      .i_unsigned   (uns),
      .o_mem_rd_en  (rd_en),
      .o_mem_addr   (mem_addr),
      .i_mem_rdata  (rdata),
      .i_mem_rvalid (rvalid),
      .o_dato       (dato),
      .o_valid      (valid),
      .o_error      (error),
      .o_stall      (stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b, expected %b", name, act, exp);
   endtask

   // ---------------- behavioural reference model ----------------
   function automatic logic model_legal(input logic [31:0] a, input logic [1:0] s);
      case (s)
         2'd0:    return (a % 32'd4) == 32'd0;
         2'd1:    return 1'b1;
         2'd2:    return (a % 32'd2) == 32'd0;
         default: return 1'b0;
      endcase
   endfunction

   // lat = index of the WAIT cycle carrying rvalid; negative = never.
   task automatic model(input logic [31:0] a, input logic [1:0] s, input logic u,
                        input logic [31:0] d, input int lat,
                        output logic [31:0] res, output logic err);
      logic [31:0] part;
      if (!model_legal(a, s) || lat < 0 || lat >= TIMEOUT) begin
         res = 32'hFFFF_FFFF;
         err = 1'b1;
      end else begin
         err = 1'b0;
         if (s == 2'd1) begin
            part = (d >> (8 * (a % 32'd4))) % 32'd256;
            res  = (!u && part >= 32'd128) ? part - 32'd256 : part;
         end else if (s == 2'd2) begin
            part = (d >> (16 * ((a / 32'd2) % 32'd2))) % 32'd65536;
            res  = (!u && part >= 32'd32768) ? part - 32'd65536 : part;
         end else begin
            res = d;
         end
      end
   endtask

   // ---------------- one complete load transaction ----------------
   task automatic run_load(input string tag, input logic [31:0] t_addr, input logic [1:0] t_size,
                           input logic t_uns, input logic [31:0] t_rdata, input int lat,
                           input logic [31:0] exp_dato, input logic exp_err);
      logic lgl;
      logic hit;
      int   nwait;
      lgl   = model_legal(t_addr, t_size);
      hit   = (lat >= 0) && (lat < TIMEOUT);
      nwait = hit ? lat + 1 : TIMEOUT;
      // IDLE with request
      @(posedge clk); #1;
      req = 1'b1; addr = t_addr; size = t_size; uns = t_uns; rvalid = 1'b0; rdata = $urandom;
      @(negedge clk);
      chk1($sformatf("%s.idle_stall", tag), stall, lgl);
      chk1($sformatf("%s.idle_valid", tag), valid, 1'b0);
      // Scramble request inputs; put stray rvalid in the REQ cycle.
      @(posedge clk); #1;
      req = 1'b0; addr = $urandom; size = 2'($urandom_range(0, 3)); uns = 1'($urandom_range(0, 1));
      rvalid = 1'b1; rdata = ~t_rdata;
      @(negedge clk);
      if (!lgl) begin
         chk1($sformatf("%s.ill_valid", tag), valid, 1'b1);
         chk1($sformatf("%s.ill_error", tag), error, exp_err);
         chk($sformatf("%s.ill_dato", tag), dato, exp_dato);
         chk1($sformatf("%s.ill_rden", tag), rd_en, 1'b0);
         chk1($sformatf("%s.ill_stall", tag), stall, 1'b0);
      end else begin
         chk1($sformatf("%s.req_rden", tag), rd_en, 1'b1);
         chk($sformatf("%s.req_addr", tag), mem_addr, t_addr & 32'hFFFF_FFFC);
         chk1($sformatf("%s.req_stall", tag), stall, 1'b1);
         chk1($sformatf("%s.req_valid", tag), valid, 1'b0);
         for (int w = 0; w < nwait; w++) begin
            @(posedge clk); #1;
            rvalid = hit && (w == lat);
            rdata  = (hit && (w == lat)) ? t_rdata : $urandom;
            @(negedge clk);
            chk1($sformatf("%s.w%0d_stall", tag, w), stall, 1'b1);
            chk1($sformatf("%s.w%0d_valid", tag, w), valid, 1'b0);
            chk1($sformatf("%s.w%0d_rden", tag, w), rd_en, 1'b0);
         end
         @(posedge clk); #1;
         rvalid = 1'b0; rdata = $urandom;
         @(negedge clk);
         chk1($sformatf("%s.done_valid", tag), valid, 1'b1);
         chk1($sformatf("%s.done_error", tag), error, exp_err);
         chk($sformatf("%s.done_dato", tag), dato, exp_dato);
         chk1($sformatf("%s.done_stall", tag), stall, 1'b0);
         chk1($sformatf("%s.done_rden", tag), rd_en, 1'b0);
         chk($sformatf("%s.done_addr", tag), mem_addr, t_addr & 32'hFFFF_FFFC);
      end
      // Back in IDLE: pulse over, result held, stray rvalid ignored.
      @(posedge clk); #1;
      rvalid = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk1($sformatf("%s.post_valid", tag), valid, 1'b0);
      chk1($sformatf("%s.post_error", tag), error, 1'b0);
      chk($sformatf("%s.post_dato", tag), dato, exp_dato);
      chk1($sformatf("%s.post_stall", tag), stall, 1'b0);
   endtask

   typedef struct {
      logic [31:0] addr;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] rdata;
      int          lat;
      logic [31:0] exp_dato;
      logic        exp_err;
   } vec_t;

   localparam int NV = 17;
   vec_t vecs [NV];

   initial begin
      logic [31:0] a_r;
      logic [1:0]  s_r;
      logic        u_r;
      logic [31:0] d_r;
      int          lat_r;
      logic [31:0] e_d;
      logic        e_e;

      vecs[0]  = '{32'h0000_0103, 2'd1, 1'b0, 32'h80FF_1234,  1, 32'hFFFF_FF80, 1'b0};
      vecs[1]  = '{32'h0000_0202, 2'd2, 1'b1, 32'hBEEF_0001,  0, 32'h0000_BEEF, 1'b0};
      vecs[2]  = '{32'h0000_0202, 2'd2, 1'b0, 32'hBEEF_0001,  0, 32'hFFFF_BEEF, 1'b0};
      vecs[3]  = '{32'h0000_0301, 2'd0, 1'b0, 32'h1234_5678,  0, 32'hFFFF_FFFF, 1'b1};
      vecs[4]  = '{32'h0000_0400, 2'd0, 1'b0, 32'h1234_5678, -1, 32'hFFFF_FFFF, 1'b1};
      vecs[5]  = '{32'h0000_0102, 2'd1, 1'b1, 32'h80FF_1234,  0, 32'h0000_00FF, 1'b0};
      vecs[6]  = '{32'h0000_0102, 2'd1, 1'b0, 32'h80FF_1234,  2, 32'hFFFF_FFFF, 1'b0};
      vecs[7]  = '{32'h0000_0100, 2'd1, 1'b0, 32'h80FF_1234,  0, 32'h0000_0034, 1'b0};
      vecs[8]  = '{32'h0000_0200, 2'd2, 1'b0, 32'h1234_8765,  2, 32'hFFFF_8765, 1'b0};
      vecs[9]  = '{32'h0000_0200, 2'd2, 1'b1, 32'h1234_8765,  0, 32'h0000_8765, 1'b0};
      vecs[10] = '{32'h0000_0201, 2'd2, 1'b0, 32'h1234_8765,  0, 32'hFFFF_FFFF, 1'b1};
      vecs[11] = '{32'h0000_0500, 2'd3, 1'b0, 32'h1234_8765,  0, 32'hFFFF_FFFF, 1'b1};
      vecs[12] = '{32'h0000_0010, 2'd0, 1'b0, 32'h1122_3344,  3, 32'h1122_3344, 1'b0};
      vecs[13] = '{32'h0000_0020, 2'd0, 1'b1, 32'h89AB_CDEF,  0, 32'h89AB_CDEF, 1'b0};
      vecs[14] = '{32'h0000_0003, 2'd1, 1'b0, 32'h7F00_0000, 15, 32'h0000_007F, 1'b0};
      vecs[15] = '{32'h0000_0404, 2'd0, 1'b0, 32'h1234_5678, 16, 32'hFFFF_FFFF, 1'b1};
      vecs[16] = '{32'h0000_0001, 2'd1, 1'b1, 32'h0000_A500,  0, 32'h0000_00A5, 1'b0};

      // Reset with a legal request pending: everything must stay quiet.
      rst = 1'b1; req = 1'b1; addr = 32'h100; size = 2'd0; uns = 1'b0;
      rdata = 32'h0; rvalid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk1("reset.rden", rd_en, 1'b0);
      chk1("reset.valid", valid, 1'b0);
      chk1("reset.error", error, 1'b0);
      chk1("reset.stall", stall, 1'b0);
      chk("reset.mem_addr", mem_addr, 32'h0);
      chk("reset.dato", dato, 32'h0);
      @(posedge clk); #1;
      req = 1'b0; rst = 1'b0;

      // Directed table
      for (int i = 0; i < NV; i++)
         run_load($sformatf("vec%0d", i), vecs[i].addr, vecs[i].size, vecs[i].uns,
                  vecs[i].rdata, vecs[i].lat, vecs[i].exp_dato, vecs[i].exp_err);

      // Held request: LW 0x10 then LW 0x14, back to back.
      @(posedge clk); #1;
      req = 1'b1; addr = 32'h10; size = 2'd0; uns = 1'b0; rvalid = 1'b0;
      for (int c = 0; c < 9; c++) begin
         if (c > 0) begin
            @(posedge clk); #1;
         end
         case (c)
            2: begin rvalid = 1'b1; rdata = 32'h1122_3344; end
            3: begin rvalid = 1'b0; addr = 32'h14; end
            6: begin rvalid = 1'b1; rdata = 32'h5566_7788; end
            7: begin rvalid = 1'b0; req = 1'b0; end
            default: ;
         endcase
         @(negedge clk);
         chk1($sformatf("hold.c%0d.stall", c), stall, (c != 3) && (c != 7) && (c != 8));
         chk1($sformatf("hold.c%0d.valid", c), valid, (c == 3) || (c == 7));
         chk1($sformatf("hold.c%0d.rden", c), rd_en, (c == 1) || (c == 5));
         if (c == 1) chk("hold.addr1", mem_addr, 32'h10);
         if (c == 5) chk("hold.addr2", mem_addr, 32'h14);
         if (c == 3) chk("hold.dato1", dato, 32'h1122_3344);
         if (c == 7) chk("hold.dato2", dato, 32'h5566_7788);
      end

      // Reset while in WAIT, rvalid arriving just after: load aborted.
      @(posedge clk); #1;
      req = 1'b1; addr = 32'h40; size = 2'd0; uns = 1'b0; rvalid = 1'b0;
      @(posedge clk); #1;
      req = 1'b0;
      @(posedge clk); #1;
      #1;
      chk1("rstwait.stall_before", stall, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      chk1("rstwait.rden", rd_en, 1'b0);
      chk1("rstwait.valid", valid, 1'b0);
      chk1("rstwait.error", error, 1'b0);
      chk1("rstwait.stall", stall, 1'b0);
      chk("rstwait.mem_addr", mem_addr, 32'h0);
      chk("rstwait.dato", dato, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0; rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      chk1("rstwait.rv_valid", valid, 1'b0);
      chk1("rstwait.rv_stall", stall, 1'b0);
      @(posedge clk); #1;
      rvalid = 1'b0;
      @(negedge clk);
      chk1("rstwait.after_valid", valid, 1'b0);
      chk1("rstwait.after_error", error, 1'b0);
      chk("rstwait.after_dato", dato, 32'h0);
      chk1("rstwait.after_rden", rd_en, 1'b0);

      // Randomized loads against the reference model.
      for (int t = 0; t < 150; t++) begin
         a_r = $urandom;
         s_r = 2'($urandom_range(0, 3));
         u_r = 1'($urandom_range(0, 1));
         d_r = $urandom;
         if ($urandom_range(0, 3) != 0) begin
            if (s_r == 2'd0) a_r[1:0] = 2'b00;
            else if (s_r == 2'd2) a_r[0] = 1'b0;
         end
         lat_r = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TIMEOUT - 1, TIMEOUT + 2))
                                            : int'($urandom_range(0, 4));
         model(a_r, s_r, u_r, d_r, lat_r, e_d, e_e);
         run_load($sformatf("rnd%0d", t), a_r, s_r, u_r, d_r, lat_r, e_d, e_e);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
